address_offset_loader: RTL and testbench



---
 rtl/address_offset_loader_pkg.sv | 24 ++
 rtl/address_offset_loader_offset_accumulator.sv | 26 ++
 rtl/address_offset_loader.sv | 181 ++++++++++++++++++
 tb/tb_address_offset_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/address_offset_loader_pkg.sv
// Shared definitions for the PO/DO offset loader and the Address Module PO entry layout.
package address_offset_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_PO_WRITE,
    ST_DO_WRITE,
    ST_FINISH
  } aol_state_e;

  localparam int PKG_ADDR_WIDTH    = 16;
  localparam int PKG_PO_INCR_WIDTH = 4;
  localparam int PO_ENTRY_WIDTH    = PKG_ADDR_WIDTH + PKG_PO_INCR_WIDTH;

  // PO entry layout seen by the Address Module: increment above the offset.
  function automatic logic [PO_ENTRY_WIDTH-1:0] pack_po_entry(
    input logic [PKG_PO_INCR_WIDTH-1:0] incr,
    input logic [PKG_ADDR_WIDTH-1:0]    offset
  );
    return {incr, offset};
  endfunction

endpackage

// File: rtl/address_offset_loader_offset_accumulator.sv
// Offset accumulator: loads the base offset, then steps by the stride, wrapping modulo 2^ADDR_WIDTH.
module offset_accumulator
  import address_offset_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = PKG_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] acc
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_value;
    end else if (step) begin
      acc <= acc + stride;
    end
  end

endmodule

// File: rtl/address_offset_loader.sv
// Programs a thread's PO entries (and optionally DO) through the Address Module write port,
// one write per granted slot of the target thread.
//
// state       | meaning
// ST_IDLE     | ready for a request
// ST_CHECK    | range-check the latched request
// ST_PO_WRITE | write PO entries on each granted slot
// ST_DO_WRITE | write DO on the next granted slot
// ST_FINISH   | request complete, done pulses next cycle
module address_offset_loader
  import address_offset_loader_pkg::*;
#(
  parameter int WRITE_ADDR_WIDTH     = 16,
  parameter int WRITE_WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH           = PKG_ADDR_WIDTH,
  parameter int PO_INCR_WIDTH        = PKG_PO_INCR_WIDTH,
  parameter int PO_ENTRY_COUNT       = 8,
  parameter int PO_ENTRY_COUNT_WIDTH = 3,
  parameter logic [WRITE_ADDR_WIDTH-1:0] PO_ADDR_BASE = 16'h0200,
  parameter logic [WRITE_ADDR_WIDTH-1:0] DO_ADDR      = 16'h0208,
  parameter int THREAD_COUNT_WIDTH   = 2
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [THREAD_COUNT_WIDTH-1:0]   req_thread,
  input  logic [PO_ENTRY_COUNT_WIDTH-1:0] req_first_entry,
  input  logic [PO_ENTRY_COUNT_WIDTH:0]   req_count,
  input  logic [ADDR_WIDTH-1:0]           req_base,
  input  logic [ADDR_WIDTH-1:0]           req_stride,
  input  logic [PO_INCR_WIDTH-1:0]        req_incr,
  input  logic                            req_do_en,
  input  logic [ADDR_WIDTH-1:0]           req_do_value,
  input  logic [THREAD_COUNT_WIDTH-1:0]   thread_current,
  input  logic                            slot_block,
  output logic                            write_en,
  output logic [WRITE_ADDR_WIDTH-1:0]     write_addr,
  output logic [WRITE_WORD_WIDTH-1:0]     write_data,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int CW          = PO_ENTRY_COUNT_WIDTH;
  localparam int ENTRY_WIDTH = ADDR_WIDTH + PO_INCR_WIDTH;

  aol_state_e state_q, state_d;

  logic [THREAD_COUNT_WIDTH-1:0] thread_q;
  logic [CW-1:0]                 first_q;
  logic [CW:0]                   remain_q;
  logic [CW:0]                   index_q;
  logic [ADDR_WIDTH-1:0]         stride_q;
  logic [ADDR_WIDTH-1:0]         do_value_q;
  logic [PO_INCR_WIDTH-1:0]      incr_q;
  logic                          do_en_q;
  logic                          range_bad_q;

  logic                          accept;
  logic                          grant;
  logic                          range_bad_req;
  logic                          po_fire;
  logic                          do_fire;
  logic [ADDR_WIDTH-1:0]         acc;
  logic [ENTRY_WIDTH-1:0]        po_entry;
  logic [WRITE_ADDR_WIDTH-1:0]   po_addr;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign grant  = (thread_current == thread_q) && !slot_block;

  // Range check is evaluated at accept so error lands in the CHECK cycle.
  assign range_bad_req = ({2'b00, req_first_entry} + {1'b0, req_count})
                         > (CW+2)'(PO_ENTRY_COUNT);

  assign po_entry = {incr_q, acc};
  assign po_addr  = PO_ADDR_BASE + WRITE_ADDR_WIDTH'(first_q) + WRITE_ADDR_WIDTH'(index_q);

  offset_accumulator #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_offset_accumulator (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .step       (po_fire),
    .load_value (req_base),
    .stride     (stride_q),
    .acc        (acc)
  );

  always_comb begin
    state_d = state_q;
    po_fire = 1'b0;
    do_fire = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (range_bad_q)           state_d = ST_IDLE;
        else if (remain_q != '0)   state_d = ST_PO_WRITE;
        else if (do_en_q)          state_d = ST_DO_WRITE;
        else                       state_d = ST_FINISH;
      end
      ST_PO_WRITE: begin
        if (grant) begin
          po_fire = 1'b1;
          if (remain_q == (CW+1)'(1)) state_d = do_en_q ? ST_DO_WRITE : ST_FINISH;
        end
      end
      ST_DO_WRITE: begin
        if (grant) begin
          do_fire = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      thread_q    <= '0;
      first_q     <= '0;
      remain_q    <= '0;
      index_q     <= '0;
      stride_q    <= '0;
      do_value_q  <= '0;
      incr_q      <= '0;
      do_en_q     <= 1'b0;
      range_bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        thread_q    <= req_thread;
        first_q     <= req_first_entry;
        remain_q    <= req_count;
        index_q     <= '0;
        stride_q    <= req_stride;
        do_value_q  <= req_do_value;
        incr_q      <= req_incr;
        do_en_q     <= req_do_en;
        range_bad_q <= range_bad_req;
      end else if (po_fire) begin
        remain_q <= remain_q - (CW+1)'(1);
        index_q  <= index_q + (CW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      done      <= (state_q == ST_FINISH);
      error     <= accept && range_bad_req;
      write_en  <= po_fire || do_fire;
      if (po_fire) begin
        write_addr <= po_addr;
        write_data <= WRITE_WORD_WIDTH'(po_entry);
      end else if (do_fire) begin
        write_addr <= DO_ADDR;
        write_data <= WRITE_WORD_WIDTH'(do_value_q);
      end else begin
        write_addr <= '0;
        write_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_address_offset_loader.sv
// Directed bench for address_offset_loader: expected writes are queued when a request is
// driven and popped as write_en appears.
module tb_address_offset_loader;

  localparam logic [1:0] TID = 2'd2;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_thread = '0;
  logic [2:0]  req_first_entry = '0;
  logic [3:0]  req_count = '0;
  logic [15:0] req_base = '0;
  logic [15:0] req_stride = '0;
  logic [3:0]  req_incr = '0;
  logic        req_do_en = 1'b0;
  logic [15:0] req_do_value = '0;
  logic [1:0]  thread_current = '0;
  logic        slot_block = 1'b0;
  logic        write_en;
  logic [15:0] write_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic        error;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   writes_seen = 0;
  int   done_seen = 0;
  int   error_seen = 0;
  int   last_write_cyc = -10;
  int   block_left = 0;
  logic had_write = 1'b0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  address_offset_loader dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_thread      (req_thread),
    .req_first_entry (req_first_entry),
    .req_count       (req_count),
    .req_base        (req_base),
    .req_stride      (req_stride),
    .req_incr        (req_incr),
    .req_do_en       (req_do_en),
    .req_do_value    (req_do_value),
    .thread_current  (thread_current),
    .slot_block      (slot_block),
    .write_en        (write_en),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs at the falling edge: checks what the last rising edge produced, then presents the next slot.
  task automatic monitor_cycle();
    exp_t e;
    if (reset_n) begin
      if (write_en) begin
        writes_seen++;
        had_write = 1'b1;
        last_write_cyc = cyc;
        chk("write_slot_thread", 64'(thread_current), 64'(TID));
        chk("write_slot_unblocked", 64'(slot_block), 64'd0);
        chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("write_addr", 64'(write_addr), 64'(e.addr));
          chk("write_data", 64'(write_data), 64'(e.data));
        end
      end else begin
        chk("idle_bus_zero", {16'(write_addr), 32'(write_data)}, 64'd0);
      end
      if (done) begin
        done_seen++;
        chk("done_all_written", 64'(exp_q.size()), 64'd0);
        chk("done_after_last_write", 64'(!had_write || (cyc == last_write_cyc + 1)), 64'd1);
      end
      if (error) error_seen++;
    end
    thread_current = thread_current + 2'd1;
    if (thread_current == TID && block_left > 0) begin
      slot_block = 1'b1;
      block_left--;
    end else begin
      slot_block = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor_cycle();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic push_model(input logic [2:0] first, input logic [3:0] count,
                            input logic [15:0] base, input logic [15:0] stride,
                            input logic [3:0] incr, input logic do_en, input logic [15:0] do_val);
    exp_t e;
    logic [15:0] off;
    off = base;
    for (int k = 0; k < int'(count); k++) begin
      e.addr = 16'h0200 + 16'(first) + 16'(k);
      e.data = {12'h000, incr, off};
      exp_q.push_back(e);
      off = off + stride;
    end
    if (do_en) begin
      e.addr = 16'h0208;
      e.data = {16'h0000, do_val};
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_req(input logic [2:0] first, input logic [3:0] count,
                           input logic [15:0] base, input logic [15:0] stride,
                           input logic [3:0] incr, input logic do_en, input logic [15:0] do_val);
    req_thread      = TID;
    req_first_entry = first;
    req_count       = count;
    req_base        = base;
    req_stride      = stride;
    req_incr        = incr;
    req_do_en       = do_en;
    req_do_value    = do_val;
    req_valid       = 1'b1;
  endtask

  task automatic run_req(input string name, input logic [2:0] first, input logic [3:0] count,
                         input logic [15:0] base, input logic [15:0] stride,
                         input logic [3:0] incr, input logic do_en, input logic [15:0] do_val,
                         input int nblock);
    logic bad;
    int   budget;
    bad = (int'(first) + int'(count)) > 8;
    if (!bad) push_model(first, count, base, stride, incr, do_en, do_val);
    had_write  = 1'b0;
    done_seen  = 0;
    error_seen = 0;
    chk({name, "_ready_before"}, 64'(req_ready), 64'd1);
    drive_req(first, count, base, stride, incr, do_en, do_val);
    tick();
    req_valid = 1'b0;
    chk({name, "_error_after_accept"}, 64'(error), 64'(bad));
    chk({name, "_busy_after_accept"}, 64'(busy), 64'd1);
    chk({name, "_ready_low_in_check"}, 64'(req_ready), 64'd0);
    tick();
    block_left = nblock;
    if (bad) begin
      chk({name, "_ready_after_error"}, 64'(req_ready), 64'd1);
      chk({name, "_idle_after_error"}, 64'(busy), 64'd0);
      chk({name, "_error_pulses"}, 64'(error_seen), 64'd1);
      repeat (3) tick();
      chk({name, "_no_done_on_error"}, 64'(done_seen), 64'd0);
    end else begin
      budget = 0;
      while (done_seen == 0 && budget < 80) begin
        tick();
        budget++;
      end
      chk({name, "_done_within_budget"}, 64'(done_seen != 0), 64'd1);
      tick();
      tick();
      chk({name, "_done_once"}, 64'(done_seen), 64'd1);
      chk({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_no_error"}, 64'(error_seen), 64'd0);
      chk({name, "_ready_after_done"}, 64'(req_ready), 64'd1);
    end
    exp_q.delete();
  endtask

  initial begin
    int budget;
    int w0;

    repeat (3) tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy_done_error_we", {busy, done, error, write_en}, 64'd0);
    chk("rst_bus", {16'(write_addr), 32'(write_data)}, 64'd0);
    reset_n = 1'b1;
    tick();

    run_req("s1_basic",   3'd1, 4'd3, 16'h0010, 16'h0004, 4'd1, 1'b0, 16'h0000, 0);
    run_req("s2_range",   3'd6, 4'd3, 16'h0010, 16'h0004, 4'd1, 1'b1, 16'h0055, 0);
    run_req("s3_do_only", 3'd0, 4'd0, 16'h0000, 16'h0000, 4'd0, 1'b1, 16'h0055, 0);
    run_req("s4_blocked", 3'd1, 4'd3, 16'h0010, 16'h0004, 4'd1, 1'b0, 16'h0000, 2);
    run_req("s5_wrap",    3'd0, 4'd3, 16'hFFFE, 16'h0001, 4'd2, 1'b0, 16'h0000, 0);
    run_req("s6_edge",    3'd5, 4'd3, 16'h0100, 16'h0020, 4'd3, 1'b1, 16'hABCD, 0);
    run_req("s7_empty",   3'd0, 4'd0, 16'h1234, 16'h0001, 4'd0, 1'b0, 16'h0000, 0);

    // Reset after the first write of the basic request.
    push_model(3'd1, 4'd3, 16'h0010, 16'h0004, 4'd1, 1'b0, 16'h0000);
    had_write = 1'b0;
    w0 = writes_seen;
    drive_req(3'd1, 4'd3, 16'h0010, 16'h0004, 4'd1, 1'b0, 16'h0000);
    tick();
    req_valid = 1'b0;
    budget = 0;
    while (writes_seen == w0 && budget < 40) begin
      tick();
      budget++;
    end
    chk("s8_first_write_seen", 64'(writes_seen - w0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("s8_rst_ready", 64'(req_ready), 64'd1);
    chk("s8_rst_busy_done_error_we", {busy, done, error, write_en}, 64'd0);
    chk("s8_rst_bus", {16'(write_addr), 32'(write_data)}, 64'd0);
    exp_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    w0 = writes_seen;
    repeat (12) tick();
    chk("s8_no_resume_writes", 64'(writes_seen - w0), 64'd0);
    chk("s8_idle_after_release", {busy, req_ready}, 64'b01);

    run_req("s9_after_reset", 3'd2, 4'd1, 16'h0077, 16'h0000, 4'd5, 1'b0, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
